// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding, default geometry widths and clog2 helper for the SA readout.
package sa_pkg;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
  localparam int SA_NBANK = 8;
  localparam int SA_COLS = 16;
  localparam int SA_CNT_W = 8;
  localparam int BANK_W = clog2(SA_NBANK);
  localparam int COL_W = clog2(SA_COLS);
  localparam int IDX_W = SA_CNT_W + BANK_W + COL_W;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/sa_reduce.sv
// sa_reduce: combinational popcount and lowest-bank/lowest-col first-match encode of masked SA data.
module sa_reduce import sa_pkg::*; #(
  parameter int NBANK = 8,
  parameter int COLS = 16,
  parameter int PCW = clog2(NBANK * COLS + 1)
) (
  input  logic [NBANK*COLS-1:0]    d,
  output logic [PCW-1:0]           popcnt,
  output logic                     any_hit,
  output logic [clog2(NBANK)-1:0]  first_bank,
  output logic [clog2(COLS)-1:0]   first_col
);
  localparam int BKW = clog2(NBANK);
  localparam int CLW = clog2(COLS);
  always_comb begin
    popcnt = '0;
    first_bank = '0;
    first_col = '0;
    for (int i = 0; i < NBANK * COLS; i++) popcnt = popcnt + PCW'(d[i]);
    // Descending scan: the last assignment is the lowest bank, then lowest col within it
    for (int b = NBANK - 1; b >= 0; b--)
      if (|d[b*COLS +: COLS]) begin
        first_bank = BKW'(b);
        for (int c = COLS - 1; c >= 0; c--)
          if (d[b*COLS + c]) first_col = CLW'(c);
      end
    any_hit = |d;
  end
endmodule

// File: rtl/sa_readout.sv
// sa_readout: captures gated SA data and reduces it to a MAC popcount sum or CAM first-match result.
module sa_readout import sa_pkg::*; #(
  parameter int NBANK = 8,
  parameter int COLS = 16,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  output logic                                         start_ready,
  input  logic                                         mode_mac,
  input  logic [CNT_W-1:0]                             num_cycles,
  input  logic [NBANK-1:0]                             sa_en,
  input  logic [NBANK*COLS-1:0]                        sa_out,
  output logic                                         res_valid,
  input  logic                                         res_ready,
  output logic [ACC_W-1:0]                             res_data,
  output logic                                         res_hit,
  output logic [CNT_W+clog2(NBANK)+clog2(COLS)-1:0]    res_idx,
  output logic                                         err_overrun
);
  localparam int BKW = clog2(NBANK);
  localparam int CLW = clog2(COLS);
  localparam int PCW = clog2(NBANK * COLS + 1);
  state_t state;
  logic mode;
  logic [CNT_W-1:0] lim, cnt;
  logic [NBANK*COLS-1:0] masked;
  logic [PCW-1:0] popcnt;
  logic any_hit, cap, last;
  logic [BKW-1:0] first_bank;
  logic [CLW-1:0] first_col;
  logic [ACC_W:0] sum;
  logic [ACC_W-1:0] nxt_acc;
  for (genvar i = 0; i < NBANK; i++)
    assign masked[i*COLS +: COLS] = sa_out[i*COLS +: COLS] & {COLS{sa_en[i]}};
  sa_reduce #(.NBANK(NBANK), .COLS(COLS), .PCW(PCW)) u_reduce (
    .d(masked), .popcnt(popcnt), .any_hit(any_hit), .first_bank(first_bank), .first_col(first_col)
  );
  // CAM mode reuses the accumulator as a saturating hit counter
  always_comb begin
    cap = |sa_en;
    sum = {1'b0, res_data} + (mode ? (ACC_W+1)'(popcnt) : (ACC_W+1)'(any_hit));
    nxt_acc = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    last = (cnt + CNT_W'(1)) == lim;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      start_ready <= 1'b1;
      res_valid <= 1'b0;
      mode <= 1'b0;
      lim <= '0;
      cnt <= '0;
      res_data <= '0;
      res_hit <= 1'b0;
      res_idx <= '0;
      err_overrun <= 1'b0;
    end else
      case (state)
        IDLE:
          if (start) begin
            mode <= mode_mac;
            lim <= num_cycles == '0 ? CNT_W'(1) : num_cycles;
            cnt <= '0;
            res_data <= '0;
            res_hit <= 1'b0;
            res_idx <= '0;
            err_overrun <= 1'b0;
            start_ready <= 1'b0;
            state <= ACCUM;
          end else if (cap) err_overrun <= 1'b1;
        ACCUM:
          if (cap) begin
            res_data <= nxt_acc;
            if (!mode && any_hit && !res_hit) begin
              res_hit <= 1'b1;
              res_idx <= {cnt, first_bank, first_col};
            end
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              res_valid <= 1'b1;
              state <= HOLD;
            end
          end
        HOLD: begin
          if (cap) err_overrun <= 1'b1;
          if (res_ready) begin
            res_valid <= 1'b0;
            start_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_sa_readout.sv
// tb_sa_readout: scoreboard bench for sa_readout; a 16-bit and an 8-bit accumulator instance share stimulus.
module tb_sa_readout;
  import sa_pkg::*;
  logic clk = 0, rst = 1, start = 0, mode_mac = 0, res_ready = 0;
  logic [7:0] num_cycles = 0, sa_en = 0;
  logic [127:0] sa_out = 0;
  logic sr0, rv0, rh0, eo0, sr1, rv1, rh1, eo1;
  logic [15:0] rd0;
  logic [7:0] rd1;
  logic [14:0] ri0, ri1;
  typedef struct {logic [15:0] d16; logic [7:0] d8; logic hit; logic [14:0] idx;} exp_t;
  exp_t sb[$];
  logic [7:0] cen[$];
  logic [127:0] cdat[$];
  int checks = 0, errors = 0;

  sa_readout u0 (.clk(clk), .rst(rst), .start(start), .start_ready(sr0), .mode_mac(mode_mac),
    .num_cycles(num_cycles), .sa_en(sa_en), .sa_out(sa_out), .res_valid(rv0), .res_ready(res_ready),
    .res_data(rd0), .res_hit(rh0), .res_idx(ri0), .err_overrun(eo0));
  sa_readout #(.ACC_W(8)) u1 (.clk(clk), .rst(rst), .start(start), .start_ready(sr1), .mode_mac(mode_mac),
    .num_cycles(num_cycles), .sa_en(sa_en), .sa_out(sa_out), .res_valid(rv1), .res_ready(res_ready),
    .res_data(rd1), .res_hit(rh1), .res_idx(ri1), .err_overrun(eo1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input bit mac, input int n);
    exp_t e;
    int s, pos, nn;
    logic [127:0] m;
    e = '{default: '0};
    s = 0;
    pos = 0;
    nn = (n == 0) ? 1 : n;
    for (int i = 0; i < nn; i++) begin
      m = cdat[i];
      for (int b = 0; b < 8; b++) if (!cen[i][b]) m[b*16 +: 16] = '0;
      if (mac) s += $countones(m);
      else if (m != 0) begin
        s++;
        if (!e.hit) begin
          e.hit = 1'b1;
          for (int p = 127; p >= 0; p--) if (m[p]) pos = p;
          e.idx = {8'(i), 3'(pos / 16), 4'(pos % 16)};
        end
      end
    end
    e.d16 = (s > 65535) ? 16'hFFFF : 16'(s);
    e.d8 = (s > 255) ? 8'hFF : 8'(s);
    sb.push_back(e);
  endtask

  task automatic collect(input int hold, input bit cap_hold);
    int w;
    exp_t e;
    w = 0;
    e = '{default: '0};
    while (!rv0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("latency", 32'(w), 0);
    if (sb.size() == 0) chk("sb_underflow", 1, 0);
    else e = sb.pop_front();
    chk("res_data", 32'(rd0), 32'(e.d16));
    chk("res_hit", 32'(rh0), 32'(e.hit));
    chk("res_idx", 32'(ri0), 32'(e.idx));
    chk("res_valid8", 32'(rv1), 1);
    chk("res_data8", 32'(rd1), 32'(e.d8));
    chk("busy", 32'(sr0), 0);
    for (int k = 0; k < hold; k++) begin
      if (cap_hold && k == 2) begin
        sa_en = 8'hFF;
        sa_out = '1;
      end
      @(negedge clk);
      sa_en = 0;
      chk("hold_valid", 32'(rv0), 1);
      chk("hold_data", 32'(rd0), 32'(e.d16));
      chk("hold_idx", 32'(ri0), 32'(e.idx));
    end
    chk("overrun", 32'(eo0), 32'(cap_hold));
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("idle_after_ack", 32'(sr0), 1);
    chk("valid_drop", 32'(rv0), 0);
  endtask

  task automatic run_op(input bit mac, input int n, input bit gaps, input int hold, input bit cap_hold);
    int nn;
    nn = (n == 0) ? 1 : n;
    model_push(mac, n);
    start = 1;
    mode_mac = mac;
    num_cycles = 8'(n);
    @(negedge clk);
    start = 0;
    for (int i = 0; i < nn; i++) begin
      sa_en = cen[i];
      sa_out = cdat[i];
      @(negedge clk);
      sa_en = 0;
      if (gaps && i < nn - 1 && $urandom_range(1) == 1) @(negedge clk);
    end
    collect(hold, cap_hold);
    cen.delete();
    cdat.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_start_ready", 32'(sr0), 1);
    chk("rst_valid", 32'(rv0), 0);
    chk("rst_data", 32'(rd0), 0);
    chk("rst_hit", 32'(rh0), 0);
    chk("rst_idx", 32'(ri0), 0);
    chk("rst_err", 32'(eo0), 0);
    rst = 0;
    @(negedge clk);
    // MAC all-ones, also saturates the 8-bit instance
    repeat (3) begin cen.push_back(8'hFF); cdat.push_back('1); end
    run_op(1, 3, 0, 0, 0);
    repeat (2) begin cen.push_back(8'h01); cdat.push_back('1); end
    run_op(1, 2, 0, 0, 0);
    // CAM first match with backpressure and a capture during HOLD
    cen.push_back(8'hFF); cdat.push_back('0);
    cen.push_back(8'hFF); cdat.push_back((128'd1 << 83) | (128'd1 << 41));
    cen.push_back(8'hFF); cdat.push_back(128'd1);
    cen.push_back(8'h01); cdat.push_back(128'd1 << 48);
    run_op(0, 4, 0, 5, 1);
    chk("err_sticky", 32'(eo0), 1);
    // start with a simultaneous capture: start wins, capture dropped silently
    cen.push_back(8'h0F); cdat.push_back({4{$urandom}});
    model_push(1, 1);
    start = 1; mode_mac = 1; num_cycles = 1; sa_en = 8'hFF; sa_out = '1;
    @(negedge clk);
    start = 0; sa_en = 0;
    chk("start_clears_err", 32'(eo0), 0);
    sa_en = cen[0]; sa_out = cdat[0];
    @(negedge clk);
    sa_en = 0;
    collect(0, 0);
    cen.delete(); cdat.delete();
    sa_en = 8'h10; sa_out = '1;
    @(negedge clk);
    sa_en = 0;
    chk("idle_capture_err", 32'(eo0), 1);
    // start during ACCUM is ignored
    cen.push_back(8'h03); cdat.push_back({4{$urandom}});
    cen.push_back(8'hC0); cdat.push_back({4{$urandom}});
    model_push(1, 2);
    start = 1; mode_mac = 1; num_cycles = 2;
    @(negedge clk);
    start = 0; sa_en = cen[0]; sa_out = cdat[0];
    @(negedge clk);
    sa_en = 0; start = 1; mode_mac = 0; num_cycles = 1;
    @(negedge clk);
    start = 0; sa_en = cen[1]; sa_out = cdat[1];
    @(negedge clk);
    sa_en = 0;
    collect(0, 0);
    cen.delete(); cdat.delete();
    // async reset mid-ACCUM
    start = 1; mode_mac = 1; num_cycles = 4;
    @(negedge clk);
    start = 0; sa_en = 8'hFF; sa_out = '1;
    @(negedge clk);
    sa_en = 0;
    #2 rst = 1;
    #1;
    chk("arst_start_ready", 32'(sr0), 1);
    chk("arst_valid", 32'(rv0), 0);
    chk("arst_data", 32'(rd0), 0);
    chk("arst_err", 32'(eo0), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    cen.push_back(8'h5A); cdat.push_back('1);
    run_op(1, 0, 0, 0, 0);
    for (int r = 0; r < 8; r++) begin
      bit mac;
      int n;
      mac = 1'($urandom_range(1));
      n = $urandom_range(0, 5);
      for (int i = 0; i < ((n == 0) ? 1 : n); i++) begin
        cen.push_back(8'($urandom_range(1, 255)));
        cdat.push_back({4{$urandom}} & {4{$urandom}} & {4{$urandom}} & {4{$urandom}});
      end
      run_op(mac, n, 1, 0, 0);
    end
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sa_readout.md
Name: sa_readout

Overview:
- Downstream consumer of the SRAM bank control stage; sits on the sense-amplifier outputs of the 8-bank array.
- Captures SA data on cycles where the bank controller asserts sa_en, then reduces it according to the operation mode:
  - MAC mode: popcount accumulation over N read cycles.
  - CAM mode: first-match priority encode over N search cycles.
- Delivers one result per operation over a valid/ready handshake to the compute/host interface.

Parameters:
- NBANK, 8, number of banks (matches the per-bank sa_en width).
- COLS, 16, SA output bits per bank.
- ACC_W, 16, MAC accumulator / result width.
- CNT_W, 8, width of the cycle-count field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  operation start pulse; accepted only when start_ready=1.
- start_ready  output  1  high in IDLE.
- mode_mac  input  1  sampled with start: 1 = MAC, 0 = CAM.
- num_cycles  input  CNT_W  sampled with start: number of captures in the operation; 0 is treated as 1.
- sa_en  input  NBANK  per-bank SA enable from the bank controller.
- sa_out  input  NBANK*COLS  SA data; bank b occupies bits [b*COLS +: COLS].
- res_valid  output  1  result available.
- res_ready  input  1  result accepted by the consumer.
- res_data  output  ACC_W  MAC sum; in CAM mode, zero-extended hit count.
- res_hit  output  1  CAM: at least one match found; MAC: 0.
- res_idx  output  CNT_W+clog2(NBANK)+clog2(COLS)  CAM first-match index {capture#, bank, col}; MAC: 0.
- err_overrun  output  1  sticky; a capture arrived while not in ACCUM. Cleared by an accepted start.

Behaviour:
- Reset: state=IDLE; start_ready=1; res_valid=0; res_data=0; res_hit=0; res_idx=0; err_overrun=0; internal counters=0.
- A capture event occurs at a rising edge where |sa_en=1. Only banks whose sa_en bit is 1 contribute; masked banks count as all-zero.
- FSM:
  - IDLE: on start, latch mode_mac and max(num_cycles,1). Clear the accumulator, capture count, hit flag, idx and err_overrun. Go to ACCUM.
  - ACCUM: on each capture event:
    - MAC: acc <= sat(acc + popcount(masked sa_out)). Saturation is at 2^ACC_W-1 and never wraps.
    - CAM: if no hit yet and any masked bit is set, record hit=1 and idx={capture#, lowest bank, lowest col in that bank}. Later matches are ignored; res_data counts captures that had any match.
    - Increment capture#. On the capture where capture# reaches the latched count, register the final result (including this capture) and go to HOLD at the same edge. res_valid is high the cycle after the last capture.
  - HOLD: res_valid=1; res_* stable. On res_valid & res_ready, go to IDLE next cycle; start_ready=1 from then.
- start outside IDLE is ignored, with no side effects.
- Capture in IDLE or HOLD is dropped and sets err_overrun=1.
- Capture 0 is the capture# value of the first capture.
- Simultaneous start and capture in IDLE: start is accepted; the capture is dropped and does not set err_overrun.
- Async reset mid-operation returns to reset values immediately; the partial result is discarded.
- Popcount and priority encode are combinational within the capture cycle; no pipelining. Adder width is ACC_W+1 internally for saturation detection.

Decomposition:
- Shared package sa_pkg holds:
  - state enum {IDLE, ACCUM, HOLD};
  - localparams BANK_W=clog2(NBANK), COL_W=clog2(COLS), IDX_W=CNT_W+BANK_W+COL_W;
  - a constant function for clog2.
- One sub-module, sa_reduce: purely combinational. It takes masked sa_out and produces popcount, any_hit, first_bank and first_col.
- The FSM, counters and result registers live in sa_readout.

Test Plan:
- MAC, num_cycles=3, sa_en=8'hFF, sa_out all-ones for 3 captures -> res_valid one cycle after the 3rd capture, res_data=384, res_hit=0.
- MAC, sa_en=8'h01, sa_out=all-ones, num_cycles=2 -> res_data=32 (banks 1–7 masked).
- CAM, num_cycles=4; capture 0 has no match, capture 1 has bank 5 col 3 and bank 2 col 9 set, capture 2 has bank 0 col 0 set -> res_hit=1, res_idx={8'd1,3'd2,4'd9}, res_data=2.
- Backpressure: hold res_ready=0 for 5 cycles with a capture during HOLD -> res_* stable, err_overrun=1; res_ready=1 -> IDLE next cycle; new start clears err_overrun.
- Saturation with ACC_W=8: MAC, num_cycles=3, all-ones captures -> res_data=255.
- Reset asserted mid-ACCUM after 1 of 4 captures -> all outputs at reset values immediately; a new start with num_cycles=0 completes after exactly 1 capture.
